gpio_debounce: RTL and testbench
================================

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width (4KB slave).
REQ-002 SHALL have port HCLK  input  1  clock; all state on rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports PADDR input APB_ADDR_WIDTH, PWDATA input 32, PWRITE input 1, PSEL input 1, PENABLE input 1: APB slave request.
REQ-005 SHALL have ports PRDATA output 32, PREADY output 1, PSLVERR output 1: APB slave response.
REQ-006 SHALL have port pad_in  input  32  raw asynchronous pad levels.
REQ-007 SHALL have port gpio_filt  output  32  debounced levels, driven into the GPIO controller gpio_in.

Function
REQ-008 SHALL tie PREADY=1 and PSLVERR=0; zero wait states.
REQ-009 SHALL decode register index from PADDR[4:2]: 0 DBEN (32b RW, per-pin filter enable), 1 PRESCALE (16b RW), 2 THRESH (4b RW), 3 FILT (32b RO, = gpio_filt), 4 CHANGED (32b, W1C); other indices read 0, writes ignored.
REQ-010 SHALL write on PSEL&PENABLE&PWRITE; PRDATA combinational from index, unused upper bits 0.
REQ-011 SHALL form s_in from pad_in per Configuration section.
REQ-012 SHALL run one shared 16-bit prescaler counter: counts 0..PRESCALE, asserts tick in the cycle where count==PRESCALE, then wraps to 0; PRESCALE=0 gives tick every cycle.
REQ-013 SHALL clear the prescaler counter to 0 in the cycle after any write to PRESCALE.
REQ-014 SHALL keep per-pin 4-bit counter cnt[i]; effective threshold T = (THRESH==0) ? 1 : THRESH.
REQ-015 Pin with DBEN[i]=0 SHALL set gpio_filt[i] <= s_in[i] every cycle and cnt[i] <= 0 (1-cycle latency from s_in).
REQ-016 Pin with DBEN[i]=1 and s_in[i]==gpio_filt[i] SHALL set cnt[i] <= 0 (glitch rejection, independent of tick).
REQ-017 Pin with DBEN[i]=1, mismatch and tick: if cnt[i]==T-1 then gpio_filt[i] <= s_in[i], cnt[i] <= 0; else cnt[i] <= cnt[i]+1.
REQ-018 Pin with DBEN[i]=1, mismatch, no tick SHALL hold cnt[i] and gpio_filt[i].
REQ-019 SHALL therefore switch an enabled output only after s_in is stable for T consecutive ticks; shorter pulses SHALL never reach gpio_filt.
REQ-020 SHALL set CHANGED[i] in the cycle gpio_filt[i] toggles, in either mode; writing 1 clears; set SHALL win over simultaneous clear.
REQ-021 Toggling DBEN[i] SHALL take effect next cycle; 1->0 releases immediately to s_in, 0->1 starts with cnt[i]=0.
REQ-022 Changing THRESH mid-count SHALL apply the new T at the next compare; cnt[i] >= T-1 with mismatch on tick SHALL switch (no wrap).

Reset
REQ-023 On HRESETn low SHALL clear DBEN, PRESCALE, THRESH, CHANGED, prescaler counter, all cnt[i], gpio_filt, and sync flops to 0, asynchronously.
REQ-024 After reset all pins SHALL be in bypass; gpio_filt follows pad_in with pipeline latency only.
REQ-025 Reset mid-count SHALL discard partial counts; no CHANGED bit set by reset release.

Configuration
REQ-026 Macro GPIO_DEBOUNCE_SYNC_EN SHALL select input synchronisation.
REQ-027 Defined: s_in = pad_in through two HCLK flops (bypass latency 3 cycles pad_in->gpio_filt).
REQ-028 Undefined: s_in = pad_in directly (pads already synchronous; bypass latency 1 cycle); register map unchanged.

Verification
REQ-029 Reset, SYNC_EN defined, DBEN=0, pad_in 0->0x0000_0001 -> gpio_filt=0x1 exactly 3 cycles later, CHANGED=0x1.
REQ-030 DBEN=0x1, PRESCALE=0, THRESH=4, pad_in[0] high for 3 cycles then low -> gpio_filt[0] stays 0, CHANGED[0]=0.
REQ-031 Same config, pad_in[0] held high -> gpio_filt[0]=1 four cycles after s_in[0] rises, CHANGED[0]=1; write 0x1 to CHANGED -> reads 0.
REQ-032 PRESCALE=9, THRESH=2, DBEN=0xFFFF_FFFF, pad_in=0xA5A5_A5A5 stable -> gpio_filt switches 20 cycles (+-10 phase) after s_in change; FILT reads 0xA5A5_A5A5.
REQ-033 CHANGED W1C write in same cycle as new toggle on that bit -> CHANGED bit remains 1.
REQ-034 Assert HRESETn low mid-count with cnt=3 -> all registers and gpio_filt read 0; after release pin in bypass.

Source files
------------

// File: rtl/gpio_debounce.sv
`timescale 1ns/1ps
// gpio_debounce: APB-configured per-pin debounce filter for 32 GPIO pads with a change-capture register.
// Build option GPIO_DEBOUNCE_SYNC_EN inserts a 2-flop synchroniser on pad_in; otherwise pads are used directly.
module gpio_debounce #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [31:0]               pad_in,
    output logic [31:0]               gpio_filt
);

    localparam logic [2:0] IDX_DBEN     = 3'd0;
    localparam logic [2:0] IDX_PRESCALE = 3'd1;
    localparam logic [2:0] IDX_THRESH   = 3'd2;
    localparam logic [2:0] IDX_FILT     = 3'd3;
    localparam logic [2:0] IDX_CHANGED  = 3'd4;

    logic        wr_en;
    logic [2:0]  reg_idx;
    logic        wr_dben;
    logic        wr_prescale;
    logic        wr_thresh;
    logic        wr_changed;

    logic [31:0] dben_q, dben_d;
    logic [15:0] prescale_q, prescale_d;
    logic [3:0]  thresh_q, thresh_d;
    logic [31:0] changed_q, changed_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic        tick;
    logic [3:0]  thresh_m1;
    logic [3:0]  cnt_q [32];
    logic [3:0]  cnt_d [32];
    logic [31:0] filt_q, filt_d;
    logic [31:0] s_in;

    logic unused_paddr;
    assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign reg_idx     = PADDR[4:2];
    assign wr_dben     = wr_en && (reg_idx == IDX_DBEN);
    assign wr_prescale = wr_en && (reg_idx == IDX_PRESCALE);
    assign wr_thresh   = wr_en && (reg_idx == IDX_THRESH);
    assign wr_changed  = wr_en && (reg_idx == IDX_CHANGED);

`ifdef GPIO_DEBOUNCE_SYNC_EN
    logic [31:0] sync1_q;
    logic [31:0] sync2_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pad_in;
            sync2_q <= sync1_q;
        end
    end

    assign s_in = sync2_q;
`else
    assign s_in = pad_in;
`endif

    // Shared prescaler: one tick per (PRESCALE+1) cycles, restarted by any PRESCALE write.
    assign tick = (pre_cnt_q == prescale_q);

    // Compare against T-1 with >= so a THRESH lowered mid-count switches instead of wrapping.
    assign thresh_m1 = (thresh_q == 4'd0) ? 4'd0 : (thresh_q - 4'd1);

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!dben_q[i]) begin
                filt_d[i] = s_in[i];
                cnt_d[i]  = 4'd0;
            end else if (s_in[i] == filt_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (tick) begin
                if (cnt_q[i] >= thresh_m1) begin
                    filt_d[i] = s_in[i];
                    cnt_d[i]  = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        dben_d     = dben_q;
        prescale_d = prescale_q;
        thresh_d   = thresh_q;
        if (wr_dben) begin
            dben_d = PWDATA;
        end
        if (wr_prescale) begin
            prescale_d = PWDATA[15:0];
        end
        if (wr_thresh) begin
            thresh_d = PWDATA[3:0];
        end
        // New toggles OR in after the clear so a set always wins over a simultaneous W1C.
        changed_d = (changed_q & ~(wr_changed ? PWDATA : 32'd0)) | (filt_d ^ filt_q);
        pre_cnt_d = (wr_prescale || tick) ? 16'd0 : (pre_cnt_q + 16'd1);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dben_q     <= '0;
            prescale_q <= '0;
            thresh_q   <= '0;
            changed_q  <= '0;
            pre_cnt_q  <= '0;
            filt_q     <= '0;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            dben_q     <= dben_d;
            prescale_q <= prescale_d;
            thresh_q   <= thresh_d;
            changed_q  <= changed_d;
            pre_cnt_q  <= pre_cnt_d;
            filt_q     <= filt_d;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        PRDATA = 32'd0;
        case (reg_idx)
            IDX_DBEN:     PRDATA = dben_q;
            IDX_PRESCALE: PRDATA = {16'd0, prescale_q};
            IDX_THRESH:   PRDATA = {28'd0, thresh_q};
            IDX_FILT:     PRDATA = filt_q;
            IDX_CHANGED:  PRDATA = changed_q;
            default:      PRDATA = 32'd0;
        endcase
    end

    assign gpio_filt = filt_q;

endmodule

// File: tb/tb_gpio_debounce.sv
`timescale 1ns/1ps
// tb_gpio_debounce: directed scenarios plus randomized pad traffic checked against a
// behavioural model of the debounce rules (stable-run length in ticks, W1C change capture).
module tb_gpio_debounce;

`ifdef GPIO_DEBOUNCE_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    localparam int LAT = DLY + 1;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic        PWRITE  = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] pad_in  = '0;
    logic [31:0] gpio_filt;

    int n_checks = 0;
    int n_pass   = 0;

    always #10 HCLK = ~HCLK;

    gpio_debounce #(.APB_ADDR_WIDTH(12)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .pad_in(pad_in), .gpio_filt(gpio_filt)
    );

    // Reference model: config, filtered level, per-pin length of the current mismatch run in ticks.
    logic [31:0] m_dben, m_changed, m_filt;
    int          m_pre, m_thr, m_phase;
    int          m_run [32];
    logic [31:0] m_hist [$];

    task automatic model_reset();
        m_dben = '0; m_changed = '0; m_filt = '0;
        m_pre = 0; m_thr = 0; m_phase = 0;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
        m_hist.delete();
        for (int i = 0; i < DLY; i++) m_hist.push_back(32'd0);
    endtask

    // Advance one clock: evaluate the model on the inputs present before the edge, then commit.
    task automatic step();
        logic        wr;
        int          idx;
        logic [31:0] s, nf, clr, pad_now, ndben;
        logic        tk;
        int          t, npre, nthr, nphase;
        int          nrun [32];
        wr = PSEL && PENABLE && PWRITE;
        idx = int'(PADDR[4:2]);
        pad_now = pad_in;
        if (DLY == 0) s = pad_in;
        else s = m_hist[m_hist.size()-1];
        tk = (m_phase == m_pre);
        t = (m_thr == 0) ? 1 : m_thr;
        nf = m_filt;
        for (int i = 0; i < 32; i++) begin
            nrun[i] = m_run[i];
            if (!m_dben[i]) begin
                nf[i] = s[i];
                nrun[i] = 0;
            end else if (s[i] == m_filt[i]) begin
                nrun[i] = 0;
            end else if (tk) begin
                if (m_run[i] + 1 >= t) begin
                    nf[i] = s[i];
                    nrun[i] = 0;
                end else begin
                    nrun[i] = m_run[i] + 1;
                end
            end
        end
        ndben = m_dben; npre = m_pre; nthr = m_thr;
        if (wr && idx == 0) ndben = PWDATA;
        if (wr && idx == 1) npre = int'(PWDATA[15:0]);
        if (wr && idx == 2) nthr = int'(PWDATA[3:0]);
        clr = (wr && idx == 4) ? PWDATA : 32'd0;
        nphase = ((wr && idx == 1) || tk) ? 0 : m_phase + 1;
        @(posedge HCLK);
        #1;
        if (!HRESETn) begin
            model_reset();
        end else begin
            m_changed = (m_changed & ~clr) | (nf ^ m_filt);
            m_filt = nf;
            m_dben = ndben; m_pre = npre; m_thr = nthr; m_phase = nphase;
            for (int i = 0; i < 32; i++) m_run[i] = nrun[i];
            if (DLY > 0) begin
                m_hist.push_front(pad_now);
                void'(m_hist.pop_back());
            end
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        step();
        PENABLE = 1'b1;
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        #1;
        d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        HRESETn = 1'b0; pad_in = '0;
        model_reset();
        step(); step();
        HRESETn = 1'b1;
        n_checks++; if (gpio_filt !== 32'd0) $display("FAIL reset_filt: got %h expected 0", gpio_filt); else n_pass++;
        n_checks++; if (PREADY !== 1'b1) $display("FAIL pready: got %b expected 1", PREADY); else n_pass++;
        n_checks++; if (PSLVERR !== 1'b0) $display("FAIL pslverr: got %b expected 0", PSLVERR); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            apb_read(12'(k * 4), d);
            n_checks++; if (d !== 32'd0) $display("FAIL reset_reg%0d: got %h expected 0", k, d); else n_pass++;
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        apb_write(12'h004, 32'hFFFF_1234);
        apb_write(12'h008, 32'h0000_00FB);
        apb_write(12'h014, 32'hDEAD_BEEF);
        apb_read(12'h004, d);
        n_checks++; if (d !== 32'h0000_1234) $display("FAIL prescale_rd: got %h expected 00001234", d); else n_pass++;
        apb_read(12'h008, d);
        n_checks++; if (d !== 32'h0000_000B) $display("FAIL thresh_rd: got %h expected 0000000b", d); else n_pass++;
        apb_read(12'h014, d);
        n_checks++; if (d !== 32'd0) $display("FAIL unmapped_rd: got %h expected 0", d); else n_pass++;
        apb_write(12'h004, 32'd0);
        apb_write(12'h008, 32'd0);
    endtask

    task automatic test_bypass();
        logic [31:0] d;
        pad_in = 32'h0000_0001;
        repeat (LAT - 1) step();
        n_checks++; if (gpio_filt !== 32'd0) $display("FAIL bypass_early: got %h expected 0", gpio_filt); else n_pass++;
        step();
        n_checks++; if (gpio_filt !== 32'h1) $display("FAIL bypass_lat: got %h expected 1", gpio_filt); else n_pass++;
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'h1) $display("FAIL bypass_changed: got %h expected 1", d); else n_pass++;
        apb_write(12'h010, 32'h1);
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'd0) $display("FAIL bypass_w1c: got %h expected 0", d); else n_pass++;
        pad_in = 32'd0;
        repeat (LAT) step();
        n_checks++; if (gpio_filt !== 32'd0) $display("FAIL bypass_fall: got %h expected 0", gpio_filt); else n_pass++;
        apb_write(12'h010, 32'hFFFF_FFFF);
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        apb_write(12'h000, 32'h1);
        apb_write(12'h004, 32'd0);
        apb_write(12'h008, 32'd4);
        pad_in = 32'h1;
        repeat (3) step();
        pad_in = 32'h0;
        for (int c = 0; c < DLY + 6; c++) begin
            step();
            n_checks++; if (gpio_filt[0] !== 1'b0) $display("FAIL glitch_filt c%0d: got %b expected 0", c, gpio_filt[0]); else n_pass++;
        end
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'd0) $display("FAIL glitch_changed: got %h expected 0", d); else n_pass++;
    endtask

    task automatic test_stable();
        logic [31:0] d;
        pad_in = 32'h1;
        repeat (DLY + 3) step();
        n_checks++; if (gpio_filt[0] !== 1'b0) $display("FAIL stable_early: got %b expected 0", gpio_filt[0]); else n_pass++;
        step();
        n_checks++; if (gpio_filt[0] !== 1'b1) $display("FAIL stable_switch: got %b expected 1", gpio_filt[0]); else n_pass++;
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'h1) $display("FAIL stable_changed: got %h expected 1", d); else n_pass++;
        apb_write(12'h010, 32'h1);
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'd0) $display("FAIL stable_w1c: got %h expected 0", d); else n_pass++;
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        int n;
        bit done;
        apb_write(12'h004, 32'd9);
        apb_write(12'h008, 32'd2);
        apb_write(12'h000, 32'hFFFF_FFFF);
        pad_in = 32'hA5A5_A5A5;
        n = 0; done = 0;
        while (!done && n < 60) begin
            step();
            n++;
            n_checks++; if (gpio_filt !== m_filt) $display("FAIL prescale_model n%0d: got %h expected %h", n, gpio_filt, m_filt); else n_pass++;
            if (gpio_filt === 32'hA5A5_A5A5) done = 1;
        end
        n_checks++;
        if (!done || (n - DLY) < 10 || (n - DLY) > 30)
            $display("FAIL prescale_delay: got %0d cycles (done=%0d) expected 10..30", n - DLY, done);
        else n_pass++;
        apb_read(12'h00C, d);
        n_checks++; if (d !== 32'hA5A5_A5A5) $display("FAIL prescale_filt_rd: got %h expected a5a5a5a5", d); else n_pass++;
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'hA5A5_A5A4) $display("FAIL prescale_changed: got %h expected a5a5a5a4", d); else n_pass++;
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        apb_write(12'h000, 32'd0);
        apb_write(12'h010, 32'hFFFF_FFFF);
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'd0) $display("FAIL coll_clear: got %h expected 0", d); else n_pass++;
        pad_in = pad_in ^ 32'h20;
        repeat (LAT) step();
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'h20) $display("FAIL coll_pre: got %h expected 20", d); else n_pass++;
        pad_in = pad_in ^ 32'h08;
        repeat (LAT - 1) step();
        PADDR = 12'h010; PWDATA = 32'h28; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b1;
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'h08) $display("FAIL coll_set_wins: got %h expected 08", d); else n_pass++;
        n_checks++; if (gpio_filt !== (32'hA5A5_A5A5 ^ 32'h28)) $display("FAIL coll_filt: got %h expected %h", gpio_filt, 32'hA5A5_A5A5 ^ 32'h28); else n_pass++;
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        pad_in = 32'd0;
        repeat (LAT) step();
        apb_write(12'h004, 32'd0);
        apb_write(12'h008, 32'd8);
        apb_write(12'h000, 32'h1);
        pad_in = 32'h1;
        repeat (DLY + 3) step();
        n_checks++; if (gpio_filt !== 32'd0) $display("FAIL midcount_pre: got %h expected 0", gpio_filt); else n_pass++;
        HRESETn = 1'b0;
        #1;
        model_reset();
        n_checks++; if (gpio_filt !== 32'd0) $display("FAIL midcount_filt: got %h expected 0", gpio_filt); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            apb_read(12'(k * 4), d);
            n_checks++; if (d !== 32'd0) $display("FAIL midcount_reg%0d: got %h expected 0", k, d); else n_pass++;
        end
        step(); step();
        HRESETn = 1'b1;
        apb_read(12'h010, d);
        n_checks++; if (d !== 32'd0) $display("FAIL midcount_release_changed: got %h expected 0", d); else n_pass++;
        repeat (LAT) step();
        n_checks++; if (gpio_filt !== 32'h1) $display("FAIL midcount_bypass: got %h expected 1", gpio_filt); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int r = 0; r < 6; r++) begin
            apb_write(12'h000, $urandom);
            apb_write(12'h004, 32'($urandom_range(0, 3)));
            apb_write(12'h008, 32'($urandom_range(0, 6)));
            for (int c = 0; c < 60; c++) begin
                if (c == 30) apb_write(12'h008, 32'($urandom_range(0, 9)));
                if ($urandom_range(0, 3) == 0) pad_in = pad_in ^ ($urandom & $urandom);
                step();
                n_checks++; if (gpio_filt !== m_filt) $display("FAIL random_filt r%0d c%0d: got %h expected %h", r, c, gpio_filt, m_filt); else n_pass++;
            end
            apb_read(12'h010, d);
            n_checks++; if (d !== m_changed) $display("FAIL random_changed r%0d: got %h expected %h", r, d, m_changed); else n_pass++;
            apb_read(12'h00C, d);
            n_checks++; if (d !== m_filt) $display("FAIL random_filt_rd r%0d: got %h expected %h", r, d, m_filt); else n_pass++;
            apb_write(12'h010, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_bypass();
        test_glitch();
        test_stable();
        test_prescale();
        test_w1c_collision();
        test_reset_midcount();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
